// File: rtl/celda_pkg.sv
// -----------------------------------------------------------------------------
// celda_pkg
// Shared definitions for the final (rightmost) cell of the iterative A>B
// comparator network.
//
// The state travelling between cells is the 2-bit pair {pout,qout}:
//   EST_A   (01) : the words are equal so far
//   EST_B   (10) : A is already known to be greater
//   EST_C   (11) : A is already known to be less
//   EST_INV (00) : illegal, never produced by a correct upstream cell
// -----------------------------------------------------------------------------
package celda_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] EST_A   = 2'b01;
    localparam logic [STATE_W-1:0] EST_B   = 2'b10;
    localparam logic [STATE_W-1:0] EST_C   = 2'b11;
    localparam logic [STATE_W-1:0] EST_INV = 2'b00;

endpackage : celda_pkg

// File: rtl/celda_final_comb.sv
// -----------------------------------------------------------------------------
// celda_final_comb
// Purely combinational result of the last comparator cell. It resolves the
// incoming state and the least-significant bit pair into the final A>B result.
//
// Parameters:
//   Z_INVALID : result produced when the incoming state is illegal (00)
// Ports:
//   state  in  [STATE_W-1:0]  {pout,qout} from the preceding cell
//   a0     in  1              LSB of word A
//   b0     in  1              LSB of word B
//   z_next out 1              1 when A > B over the full word
// -----------------------------------------------------------------------------
module celda_final_comb
    import celda_pkg::*;
#(
    parameter logic Z_INVALID = 1'b0
) (
    input  logic [STATE_W-1:0] state,
    input  logic               a0,
    input  logic               b0,
    output logic               z_next
);

    always_comb begin
        z_next = Z_INVALID;
        unique case (state)
            EST_A:   z_next = a0 & ~b0;   // still tied: the LSBs decide
            EST_B:   z_next = 1'b1;       // LSBs are irrelevant once decided
            EST_C:   z_next = 1'b0;
            default: z_next = Z_INVALID;
        endcase
    end

endmodule : celda_final_comb

// File: rtl/celda_final_izq_der.sv
// -----------------------------------------------------------------------------
// celda_final_izq_der
// Final cell of a left-to-right iterative A>B comparator. Registers the
// combinational result with a one-cycle latency and full throughput.
//
// Optional feature: define CELDA_FINAL_ERR_EN to add a sticky err output that
// flags any valid sample carrying the illegal state 00. Without the macro the
// err port and its register do not exist; Zout/valid_out are unchanged.
//
// Parameters:
//   Z_INVALID : Zout value produced for the illegal incoming state
// Ports:
//   clk       in  1  rising-edge clock
//   reset     in  1  synchronous, active-high reset
//   pout      in  1  MSB of present state from preceding cell
//   qout      in  1  LSB of present state from preceding cell
//   A0        in  1  LSB of word A
//   B0        in  1  LSB of word B
//   valid_in  in  1  qualifies pout/qout/A0/B0 on this edge
//   Zout      out 1  registered result, 1 when A > B
//   valid_out out 1  Zout carries a result sampled on the previous edge
//   err       out 1  sticky illegal-state flag (CELDA_FINAL_ERR_EN only)
// -----------------------------------------------------------------------------
module celda_final_izq_der
    import celda_pkg::*;
#(
    parameter logic Z_INVALID = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pout,
    input  logic qout,
    input  logic A0,
    input  logic B0,
    input  logic valid_in,
    output logic Zout,
    output logic valid_out
`ifdef CELDA_FINAL_ERR_EN
    ,
    output logic err
`endif
);

    logic [STATE_W-1:0] state;
    logic               z_next;

    assign state = {pout, qout};

    celda_final_comb #(
        .Z_INVALID (Z_INVALID)
    ) u_comb (
        .state  (state),
        .a0     (A0),
        .b0     (B0),
        .z_next (z_next)
    );

    // Output register: a sample arriving together with reset is discarded.
    // Zout keeps its last result while no new sample arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            Zout      <= 1'b0;
            valid_out <= 1'b0;
        end else if (valid_in) begin
            Zout      <= z_next;
            valid_out <= 1'b1;
        end else begin
            valid_out <= 1'b0;
        end
    end

`ifdef CELDA_FINAL_ERR_EN
    // Sticky until reset so a transient upstream fault is never missed.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (valid_in && (state == EST_INV)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule : celda_final_izq_der

// File: tb/tb_celda_final_izq_der.sv
// -----------------------------------------------------------------------------
// tb_celda_final_izq_der
// Scoreboard bench for celda_final_izq_der. Stimulus pushes one expected
// record per clock edge; a monitor pops on the following falling edge and
// compares valid_out, Zout and (with CELDA_FINAL_ERR_EN) err.
// -----------------------------------------------------------------------------
module tb_celda_final_izq_der;

    localparam logic ZI = 1'b1;   // distinct from state c so 00 is observable

    logic clk = 1'b0;
    logic reset, pout, qout, A0, B0, valid_in;
    logic Zout, valid_out;
`ifdef CELDA_FINAL_ERR_EN
    logic err;
`endif

    always #5 clk = ~clk;

    celda_final_izq_der #(
        .Z_INVALID (ZI)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pout      (pout),
        .qout      (qout),
        .A0        (A0),
        .B0        (B0),
        .valid_in  (valid_in),
        .Zout      (Zout),
        .valid_out (valid_out)
`ifdef CELDA_FINAL_ERR_EN
        ,
        .err       (err)
`endif
    );

    typedef struct {
        logic vld;
        logic z;
        logic e;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: last published result and sticky error.
    logic m_z   = 1'b0;
    logic m_err = 1'b0;

    // Final cell meaning: the prefix already decides A vs B, unless it is
    // still a tie, in which case the LSB pair decides A > B.
    function automatic logic ref_result(input logic [1:0] st, input logic a, input logic b);
        int av, bv;
        av = a;
        bv = b;
        if (st == 2'b01) return (av > bv);
        if (st == 2'b10) return 1'b1;
        if (st == 2'b11) return 1'b0;
        return ZI;
    endfunction

    task automatic drive(input logic r, input logic v, input logic [1:0] st,
                         input logic a, input logic b);
        exp_t e;
        reset    = r;
        valid_in = v;
        {pout, qout} = st;
        A0 = a;
        B0 = b;
        @(posedge clk);
        if (r) begin
            m_z   = 1'b0;
            m_err = 1'b0;
            e.vld = 1'b0;
        end else if (v) begin
            m_z = ref_result(st, a, b);
            if (st == 2'b00) m_err = 1'b1;
            e.vld = 1'b1;
        end else begin
            e.vld = 1'b0;
        end
        e.z = m_z;
        e.e = m_err;
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: compares DUT outputs away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (valid_out !== e.vld) begin
                    failures++;
                    $display("FAIL valid_out t=%0t got=%b exp=%b", $time, valid_out, e.vld);
                end
                checks++;
                if (Zout !== e.z) begin
                    failures++;
                    $display("FAIL zout t=%0t got=%b exp=%b", $time, Zout, e.z);
                end
`ifdef CELDA_FINAL_ERR_EN
                checks++;
                if (err !== e.e) begin
                    failures++;
                    $display("FAIL err t=%0t got=%b exp=%b", $time, err, e.e);
                end
`endif
            end
        end
    end

    // Watchdog: the stimulus is finite, this only guards against a stall.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] st;
        reset = 1'b1; valid_in = 1'b0; pout = 1'b0; qout = 1'b0; A0 = 1'b0; B0 = 1'b0;

        // Reset state
        drive(1, 0, 2'b00, 0, 0);
        drive(1, 1, 2'b10, 1, 0);

        // State a, AB = 00/01/10/11 back to back
        for (int i = 0; i < 4; i++) drive(0, 1, 2'b01, i[1], i[0]);
        // State b and state c, all AB
        for (int i = 0; i < 4; i++) drive(0, 1, 2'b10, i[1], i[0]);
        for (int i = 0; i < 4; i++) drive(0, 1, 2'b11, i[1], i[0]);

        // Single pulse then idle: Zout held, valid_out one cycle only
        drive(0, 1, 2'b10, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 2'b11, 0, 1);

        // Reset together with a valid sample in state b
        drive(1, 1, 2'b10, 0, 0);
        drive(0, 0, 2'b01, 0, 0);

        // Illegal state, then legal traffic: err stays sticky
        drive(0, 1, 2'b00, 1, 0);
        drive(0, 1, 2'b01, 1, 0);
        drive(0, 1, 2'b11, 0, 0);
        drive(0, 0, 2'b00, 0, 0);
        drive(1, 0, 2'b00, 0, 0);

        // 12 consecutive samples covering a/b/c x AB
        for (int s = 1; s < 4; s++)
            for (int i = 0; i < 4; i++) begin
                st = s[1:0];
                drive(0, 1, st, i[1], i[0]);
            end

        // Randomized traffic with occasional resets and illegal states
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end
        drive(0, 0, 2'b00, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_celda_final_izq_der
